mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single CPU memory between two requesters: the CPU datapath (port C) and a
//  host loader/debug port (port H). Single-beat req/gnt transfers, registered memory-side
//  strobes, and a burst limit so neither port starves. Sits between cpu/host and mem.
// PARAMETERS
//  AW         5  address width (32-word memory)
//  DW         8  data width
//  MAX_BURST  4  max consecutive beats an owner keeps while the other port waits (>=1)
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  rst        in   1   synchronous reset, active-high
//  c_req      in   1   CPU transfer request; hold with c_we/c_addr/c_wdata stable until c_gnt
//  c_we       in   1   1 = write, 0 = read
//  c_addr     in   AW  CPU address
//  c_wdata    in   DW  CPU write data
//  c_gnt      out  1   combinational; c_req&c_gnt = CPU beat accepted this cycle
//  c_rvalid   out  1   CPU read data valid on rdata
//  h_req/h_we/h_addr/h_wdata/h_gnt/h_rvalid  same as the C* ports, for the host
//  rdata      out  DW  shared read data, pass-through of mem_rdata; qualify with *_rvalid
//  mem_read   out  1   registered read strobe to memory
//  mem_write  out  1   registered write strobe to memory
//  mem_addr   out  AW  registered address
//  mem_wdata  out  DW  registered write data
//  mem_rdata  in   DW  memory read data, valid 1 cycle after mem_read
// BEHAVIOUR
//  Reset: state IDLE, burst_cnt=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0,
//   c_rvalid=h_rvalid=0, read-pending pipe cleared; last_grant=H (so C wins first under RR).
//   While rst=1, c_gnt=h_gnt=0.
//  Transfer: accepted in cycle N (req&gnt). N+1: mem_read|mem_write=1, mem_addr/wdata from
//   the winner. Read: N+2 winner's *_rvalid=1, rdata=mem_rdata. At most one gnt per cycle.
//   Back-to-back beats every cycle; strobes drop to 0 in any cycle following no acceptance.
//  FSM states IDLE, OWN_C, OWN_H; burst_cnt saturates at MAX_BURST:
//   IDLE:  only one req -> grant it; both -> winner per arbitration rule. Go OWN_x, cnt=1.
//          No req -> stay IDLE.
//   OWN_x: x_req & (cnt<MAX_BURST | ~other_req) -> grant x, cnt=min(cnt+1,MAX_BURST).
//          else other_req -> grant other, go OWN_other, cnt=1.
//          else -> no grant, go IDLE, cnt=0.
//  Every grant updates last_grant.
//  Boundaries: owner dropping req with the other requesting -> switch that same cycle with no
//   idle gap. MAX_BURST=1 -> strict alternation under contention. Read and write to the same
//   address in consecutive beats complete in acceptance order. Reset mid-operation: a read
//   accepted in the reset cycle or the cycle before it produces no rvalid, and the strobes
//   clear next cycle.
// CONFIGURATION
//  ARB_RR_EN defined: IDLE tie-break grants the port != last_grant (round-robin).
//  ARB_RR_EN undefined: IDLE tie-break always grants C (fixed priority). Burst limit applies
//   in both builds.
// STRUCTURE
//  cpu_rtl_pkg gains arb_state_t (IDLE, OWN_C, OWN_H) and arb_port_t (PORT_C, PORT_H).
//  Read-pending tag: 2-bit pipe {valid, port}. burst_cnt width $clog2(MAX_BURST+1).
//  No sub-module; FSM, grant logic and output registers are kept in one module.
// TESTING
//  1 rst=1 for 2 cycles with both reqs high -> gnts 0; all outputs 0; IDLE after release.
//  2 c_req read addr 5'h03, mem[3]=8'hA5 -> c_gnt at N; mem_read=1, mem_addr=3 at N+1;
//    c_rvalid=1, rdata=8'hA5 at N+2; h_rvalid stays 0.
//  3 h_req write addr 5'h1F, wdata 8'h3C, CPU idle -> h_gnt at N; N+1 mem_write=1,
//    addr=1F, wdata=3C; no rvalid.
//  4 both req from IDLE twice (drop both between) -> fixed: C, C; ARB_RR_EN: C then H.
//  5 c_req held continuously, h_req raised -> exactly 4 C beats, then H granted; C
//    regranted after 4 H beats or when h_req drops.
//  6 C read accepted, rst=1 next cycle -> c_rvalid never asserts; mem_read=0 after rst.

Source files
------------

// File: rtl/cpu_rtl_pkg.sv
// Shared types for the CPU memory subsystem.
// Provides arbiter state/port enums, the read-pending tag and a port helper.
package cpu_rtl_pkg;

    // Arbiter ownership state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_H = 2'd2
    } arb_state_t;

    // Requester identity.
    typedef enum logic {
        PORT_C = 1'b0,
        PORT_H = 1'b1
    } arb_port_t;

    // Tag travelling with an accepted read until its data returns.
    typedef struct packed {
        logic      valid;
        arb_port_t port;
    } rd_tag_t;

    function automatic arb_port_t other_port(arb_port_t p);
        return (p == PORT_C) ? PORT_H : PORT_C;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port single-beat memory arbiter (CPU port C, host port H).
// Ports: clk, rst (sync, active-high); c_*/h_* req/we/addr/wdata in,
//   gnt (combinational) and rvalid out; rdata shared read data;
//   mem_read/mem_write/mem_addr/mem_wdata registered strobes, mem_rdata in.
// Build option: define ARB_RR_EN for round-robin IDLE tie-break,
//   otherwise the CPU port wins ties. The burst limit applies in both.
module mem_arbiter
    import cpu_rtl_pkg::*;
#(
    parameter int AW        = 5,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,

    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,

    output logic [DW-1:0] rdata,

    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    arb_state_t    state;
    logic [CW-1:0] burst_cnt;
    rd_tag_t       pend;
    arb_port_t     tie_winner;

    logic          gnt_c;
    logic          gnt_h;
    logic          any_gnt;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          below_max;
    logic [CW-1:0] cnt_inc;

`ifdef ARB_RR_EN
    arb_port_t     last_grant;

    // Favour whichever port was not served by the most recent grant.
    assign tie_winner = other_port(last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_H;
        end else if (gnt_c) begin
            last_grant <= PORT_C;
        end else if (gnt_h) begin
            last_grant <= PORT_H;
        end
    end
`else
    assign tie_winner = PORT_C;
`endif

    assign below_max = (burst_cnt < CNT_MAX);
    assign cnt_inc   = below_max ? burst_cnt + CNT_ONE : CNT_MAX;

    // Grant decision. The owner keeps the memory until it either
    // stops asking or has used its burst while the other port waits.
    always_comb begin
        gnt_c = 1'b0;
        gnt_h = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (c_req && h_req) begin
                        gnt_c = (tie_winner == PORT_C);
                        gnt_h = (tie_winner == PORT_H);
                    end else begin
                        gnt_c = c_req;
                        gnt_h = h_req;
                    end
                end
                OWN_C: begin
                    if (c_req && (below_max || !h_req)) begin
                        gnt_c = 1'b1;
                    end else begin
                        gnt_h = h_req;
                    end
                end
                OWN_H: begin
                    if (h_req && (below_max || !c_req)) begin
                        gnt_h = 1'b1;
                    end else begin
                        gnt_c = c_req;
                    end
                end
                default: begin
                    gnt_c = 1'b0;
                    gnt_h = 1'b0;
                end
            endcase
        end
    end

    assign c_gnt   = gnt_c;
    assign h_gnt   = gnt_h;
    assign any_gnt = gnt_c | gnt_h;

    assign sel_we    = gnt_h ? h_we    : c_we;
    assign sel_addr  = gnt_h ? h_addr  : c_addr;
    assign sel_wdata = gnt_h ? h_wdata : c_wdata;

    // Ownership FSM and burst counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else if (gnt_c) begin
            state     <= OWN_C;
            burst_cnt <= (state == OWN_C) ? cnt_inc : CNT_ONE;
        end else if (gnt_h) begin
            state     <= OWN_H;
            burst_cnt <= (state == OWN_H) ? cnt_inc : CNT_ONE;
        end else begin
            state     <= IDLE;
            burst_cnt <= '0;
        end
    end

    // Memory-side strobes and the read-return pipe. The pending tag
    // lines up with mem_rdata one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pend      <= '0;
            c_rvalid  <= 1'b0;
            h_rvalid  <= 1'b0;
        end else begin
            mem_read  <= any_gnt & ~sel_we;
            mem_write <= any_gnt & sel_we;
            if (any_gnt) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            pend.valid <= any_gnt & ~sel_we;
            pend.port  <= gnt_h ? PORT_H : PORT_C;
            c_rvalid   <= pend.valid && (pend.port == PORT_C);
            h_rvalid   <= pend.valid && (pend.port == PORT_H);
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter.
// Arbitration, strobes and read returns checked against a reference model.
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          h_req, h_we, h_gnt, h_rvalid;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic [DW-1:0] rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(int i);
        if (i == 3) return 8'hA5;
        return 8'(i * 29 + 7);
    endfunction

    // Memory attached to the DUT: one-cycle registered read.
    logic [DW-1:0] ram [2**AW];
    bit            loaded;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 2**AW; i++) ram[i] <= init_val(i);
            loaded <= 1'b1;
        end else begin
            if (mem_write) ram[mem_addr] <= mem_wdata;
            if (mem_read) mem_rdata <= ram[mem_addr];
        end
    end

    int vec = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            due;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } stb_t;

    typedef struct {
        int            due;
        bit            is_h;
        logic [DW-1:0] d;
    } rd_t;

    stb_t          sq [$];
    rd_t           rq [$];
    logic [DW-1:0] model_mem [2**AW];

    // Reference: who owns the memory, how many beats in a row it has
    // had, and which port was served last (1 = C, 2 = H).
    int own    = 0;
    int streak = 0;
    int last   = 2;

    always @(negedge clk) begin : model
        int            eg;
        bit            mine, oth, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        stb_t          s;
        rd_t           r;

        if (sq.size() > 0 && sq[0].due == cyc) begin
            s = sq.pop_front();
            chk("mem_read", mem_read, !s.we);
            chk("mem_write", mem_write, s.we);
            chk("mem_addr", mem_addr, s.a);
            if (s.we) chk("mem_wdata", mem_wdata, s.d);
        end else begin
            chk("mem_read_idle", mem_read, 0);
            chk("mem_write_idle", mem_write, 0);
        end

        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            chk("c_rvalid", c_rvalid, !r.is_h);
            chk("h_rvalid", h_rvalid, r.is_h);
            chk("rdata", rdata, r.d);
        end else begin
            chk("c_rvalid_idle", c_rvalid, 0);
            chk("h_rvalid_idle", h_rvalid, 0);
        end

        eg = 0;
        if (!rst) begin
            if (own == 0) begin
                if (c_req && h_req) begin
`ifdef ARB_RR_EN
                    eg = (last == 2) ? 1 : 2;
`else
                    eg = 1;
`endif
                end else if (c_req) begin
                    eg = 1;
                end else if (h_req) begin
                    eg = 2;
                end
            end else begin
                mine = (own == 1) ? c_req : h_req;
                oth  = (own == 1) ? h_req : c_req;
                if (mine && (streak < MB || !oth)) eg = own;
                else if (oth) eg = 3 - own;
            end
        end
        chk("c_gnt", c_gnt, eg == 1);
        chk("h_gnt", h_gnt, eg == 2);

        if (rst) begin
            own = 0;
            streak = 0;
            last = 2;
            while (sq.size() > 0 && sq[$].due > cyc) void'(sq.pop_back());
            while (rq.size() > 0 && rq[$].due > cyc) void'(rq.pop_back());
        end else if (eg != 0) begin
            streak = (own == eg) ? ((streak < MB) ? streak + 1 : MB) : 1;
            own  = eg;
            last = eg;
            we = (eg == 1) ? c_we : h_we;
            a  = (eg == 1) ? c_addr : h_addr;
            d  = (eg == 1) ? c_wdata : h_wdata;
            sq.push_back('{cyc + 1, we, a, d});
            if (we) model_mem[a] = d;
            else rq.push_back('{cyc + 2, eg == 2, model_mem[a]});
        end else begin
            own = 0;
            streak = 0;
        end
    end

    bit c_acc, h_acc;

    task automatic tick();
        @(negedge clk);
        c_acc = c_req && c_gnt;
        h_acc = h_req && h_gnt;
        @(posedge clk);
        #1;
    endtask

    // Random traffic; a pending request is held until accepted.
    task automatic rnd(int pc, int ph, int prst);
        rst = int'($urandom_range(0, 999)) < prst;
        if (!c_req || c_acc) begin
            c_req   = int'($urandom_range(0, 99)) < pc;
            c_we    = 1'($urandom);
            c_addr  = $urandom_range(0, 1) ? AW'($urandom_range(0, 3))
                                            : AW'($urandom);
            c_wdata = DW'($urandom);
        end
        if (!h_req || h_acc) begin
            h_req   = int'($urandom_range(0, 99)) < ph;
            h_we    = 1'($urandom);
            h_addr  = $urandom_range(0, 1) ? AW'($urandom_range(0, 3))
                                            : AW'($urandom);
            h_wdata = DW'($urandom);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) model_mem[i] = init_val(i);
        rst = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        h_req = 1'b1; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        tick();
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_h_rvalid", h_rvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; c_req = 1'b0; h_req = 1'b0;
        tick();

        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h03;
        tick();
        c_req = 1'b0;
        repeat (3) tick();

        h_req = 1'b1; h_we = 1'b1; h_addr = 5'h1F; h_wdata = 8'h3C;
        tick();
        h_req = 1'b0;
        repeat (3) tick();

        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h01;
        h_req = 1'b1; h_we = 1'b0; h_addr = 5'h02;
        tick();
        c_req = 1'b0; h_req = 1'b0;
        tick();
        c_req = 1'b1; h_req = 1'b1;
        tick();
        c_req = 1'b0; h_req = 1'b0;
        repeat (3) tick();

        repeat (3) rnd(100, 0, 0);
        repeat (24) rnd(100, 100, 0);
        repeat (6) rnd(100, 0, 0);
        repeat (4) rnd(0, 0, 0);
        repeat (6) rnd(0, 0, 0);

        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h03;
        tick();
        c_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        for (int p = 0; p < 8; p++) begin
            int pc, ph;
            pc = int'($urandom_range(10, 100));
            ph = int'($urandom_range(10, 100));
            repeat (500) rnd(pc, ph, 4);
        end
        repeat (10) rnd(0, 0, 0);
        chk("sq_drain", sq.size(), 0);
        chk("rq_drain", rq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
